// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the multi-channel level-to-pulse converter:
// edge-mode codes, channel state encoding, parameter limits and the edge rule.
package pulse_gen_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam int MAX_SYNC_STAGES = 4;
  localparam int MAX_PULSE_LEN   = 255;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Mode bit 0 enables rising edges and bit 1 enables falling edges, so
  // MODE_BOTH accepts either and MODE_OFF suppresses detection entirely.
  function automatic logic edge_hit(input logic [1:0] mode,
                                    input logic       s,
                                    input logic       prev);
    return (mode[0] & s & ~prev) | (mode[1] & ~s & prev);
  endfunction

endpackage

// File: rtl/multi_pulse_gen_if.sv
// Control/status bundle of the pulse generator: level inputs, edge modes and
// MISSED clears towards the block, pulses and status flags back out.
interface multi_pulse_gen_if #(
  parameter int NUM_CH = 4
);

  logic [NUM_CH-1:0]   LVL_SIG;
  logic [2*NUM_CH-1:0] EDGE_MODE;
  logic [NUM_CH-1:0]   MISSED_CLR;
  logic [NUM_CH-1:0]   PULSE_SIG;
  logic [NUM_CH-1:0]   BUSY;
  logic [NUM_CH-1:0]   MISSED;

  modport master (
    output LVL_SIG,
    output EDGE_MODE,
    output MISSED_CLR,
    input  PULSE_SIG,
    input  BUSY,
    input  MISSED
  );

  modport slave (
    input  LVL_SIG,
    input  EDGE_MODE,
    input  MISSED_CLR,
    output PULSE_SIG,
    output BUSY,
    output MISSED
  );

endinterface

// File: rtl/pulse_gen_ch.sv
// One channel: optional synchroniser, edge detector, stretch counter with
// retrigger policy and a sticky missed-edge flag.
module pulse_gen_ch
  import pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1,
  parameter int RETRIG      = 1,
  parameter int CNT_W       = $clog2(PULSE_LEN + 1)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       lvl_i,
  input  logic [1:0] mode_i,
  input  logic       missed_clr_i,
  output logic       pulse_o,
  output logic       busy_o,
  output logic       missed_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

  logic             s;
  logic             prev_q;
  logic             edge_det;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             missed_q, missed_d;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = lvl_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: flops are always written with <= so every stage samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge CLK) begin
      if (RST) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= lvl_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  // prev keeps tracking s even in MODE_OFF, so re-enabling never sees a
  // stale level as a fresh edge.
  assign edge_det = edge_hit(mode_i, s, prev_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q   <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      prev_q   <= s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // left one unassigned would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    missed_d = missed_q;

    if (missed_clr_i) begin
      missed_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (edge_det) begin
          state_d = ST_ACTIVE;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_ACTIVE: begin
        if (edge_det && (RETRIG != 0)) begin
          cnt_d = CNT_LOAD;
        end else begin
          // An ignored edge sets MISSED, overriding a clear in the same cycle.
          if (edge_det) begin
            missed_d = 1'b1;
          end
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
    endcase
  end

  assign pulse_o  = (state_q == ST_ACTIVE);
  assign busy_o   = pulse_o;
  assign missed_o = (RETRIG != 0) ? 1'b0 : missed_q;

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-channel level-to-pulse converter: parameter range checks plus one
// independent pulse_gen_ch per channel, with no arbitration between them.
module multi_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int PULSE_LEN   = 1,
  parameter  int RETRIG      = 1,
  localparam int CNT_W       = $clog2(PULSE_LEN + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  multi_pulse_gen_if.slave  bus
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("multi_pulse_gen: NUM_CH must be at least 1");
  end
  if ((SYNC_STAGES < 0) || (SYNC_STAGES > MAX_SYNC_STAGES)) begin : g_bad_sync
    $error("multi_pulse_gen: SYNC_STAGES out of range 0..4");
  end
  if ((PULSE_LEN < 1) || (PULSE_LEN > MAX_PULSE_LEN)) begin : g_bad_len
    $error("multi_pulse_gen: PULSE_LEN out of range 1..255");
  end
  if ((RETRIG != 0) && (RETRIG != 1)) begin : g_bad_retrig
    $error("multi_pulse_gen: RETRIG must be 0 or 1");
  end

  logic [NUM_CH-1:0] pulse_w;
  logic [NUM_CH-1:0] busy_w;
  logic [NUM_CH-1:0] missed_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_gen_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .PULSE_LEN   (PULSE_LEN),
      .RETRIG      (RETRIG),
      .CNT_W       (CNT_W)
    ) u_ch (
      .CLK          (CLK),
      .RST          (RST),
      .lvl_i        (bus.LVL_SIG[i]),
      .mode_i       (bus.EDGE_MODE[2*i +: 2]),
      .missed_clr_i (bus.MISSED_CLR[i]),
      .pulse_o      (pulse_w[i]),
      .busy_o       (busy_w[i]),
      .missed_o     (missed_w[i])
    );
  end

  assign bus.PULSE_SIG = pulse_w;
  assign bus.BUSY      = busy_w;
  assign bus.MISSED    = missed_w;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Bench for multi_pulse_gen: four parameterisations share one stimulus stream
// and are each compared every cycle against an end-time based pulse model.
module tb_multi_pulse_gen;

  localparam int NCH  = 4;
  localparam int NCFG = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   lvl;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0]   clr;
  bit               cmp_en = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  logic [NCH-1:0] pulse_w  [NCFG];
  logic [NCH-1:0] missed_w [NCFG];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // cfg: 0 = S2/L1/R1, 1 = S2/L4/R1, 2 = S1/L3/R1, 3 = S0/L5/R0
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int S = (g == 2) ? 1 : (g == 3) ? 0 : 2;
    localparam int L = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 3 : 5;
    localparam int R = (g == 3) ? 0 : 1;

    multi_pulse_gen_if #(.NUM_CH(NCH)) bus ();

    assign bus.LVL_SIG    = lvl;
    assign bus.EDGE_MODE  = mode;
    assign bus.MISSED_CLR = clr;
    assign pulse_w[g]     = bus.PULSE_SIG;
    assign missed_w[g]    = bus.MISSED;

    multi_pulse_gen #(
      .NUM_CH      (NCH),
      .SYNC_STAGES (S),
      .PULSE_LEN   (L),
      .RETRIG      (R)
    ) u_dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
    );

    // Model: the pulse is high after clock edge k iff k <= until[c], where an
    // accepted edge at k sets until = k+L-1. The synchroniser is a plain
    // S-cycle delay of the sampled level, with reset zeroing the sample history.
    int             cyc = 0;
    int             until_c [NCH];
    logic [7:0]     hist    [NCH];
    logic [NCH-1:0] exp_pulse  = '0;
    logic [NCH-1:0] exp_missed = '0;

    always @(posedge clk) begin
      logic [8:0] h;
      logic [1:0] m;
      logic       s, p, e, act;
      cyc++;
      for (int c = 0; c < NCH; c++) begin
        h = {hist[c], lvl[c]};
        m = mode[2*c +: 2];
        if (rst) begin
          hist[c]       = '0;
          until_c[c]    = cyc - 1;
          exp_missed[c] = 1'b0;
        end else begin
          s   = h[S];
          p   = h[S+1];
          e   = (m[0] && s && !p) || (m[1] && !s && p);
          act = ((cyc - 1) <= until_c[c]);
          if (e && (R == 1 || !act)) until_c[c] = cyc + L - 1;
          if (e && act && R == 0)    exp_missed[c] = 1'b1;
          else if (clr[c])           exp_missed[c] = 1'b0;
          hist[c] = h[7:0];
        end
        exp_pulse[c] = (cyc <= until_c[c]);
      end
    end

    always @(negedge clk) begin
      if (cmp_en) begin
        check($sformatf("cfg%0d PULSE_SIG", g), 32'(bus.PULSE_SIG), 32'(exp_pulse));
        check($sformatf("cfg%0d BUSY", g),      32'(bus.BUSY),      32'(exp_pulse));
        check($sformatf("cfg%0d MISSED", g),    32'(bus.MISSED),    32'(exp_missed));
      end
    end
  end

  // Observation of one channel of one configuration over a window.
  int o_first, o_width, o_runs;
  bit o_last;

  task automatic obs_reset();
    o_first = 0; o_width = 0; o_runs = 0; o_last = 1'b0;
  endtask

  task automatic obs_sample(input int cfg, input int ch, input int j);
    bit v;
    v = pulse_w[cfg][ch];
    if (v) begin
      o_width++;
      if (o_first == 0) o_first = j;
      if (!o_last) o_runs++;
    end
    o_last = v;
  endtask

  initial begin
    int hi_cnt;
    bit seen;

    // Reset held with all levels high, rising mode everywhere.
    rst = 1'b1; lvl = 4'hF; mode = 8'h55; clr = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset PULSE_SIG cfg0", 32'(pulse_w[0]), 32'h0);
    check("reset MISSED cfg3",    32'(missed_w[3]), 32'h0);
    rst = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check($sformatf("release cycle %0d cfg0", j), 32'(pulse_w[0]), (j == 3) ? 32'hF : 32'h0);
    end
    check("release MISSED cfg0", 32'(missed_w[0]), 32'h0);
    repeat (8) @(negedge clk);

    // Falling mode on ch0, PULSE_LEN=4 (cfg1): fall fires, rise does not.
    mode = 8'h56; lvl[0] = 1'b0;
    obs_reset();
    for (int j = 1; j <= 10; j++) begin @(negedge clk); obs_sample(1, 0, j); end
    check("fall first", o_first, 3);
    check("fall width", o_width, 4);
    check("fall runs",  o_runs,  1);
    lvl[0] = 1'b1;
    obs_reset();
    for (int j = 1; j <= 8; j++) begin @(negedge clk); obs_sample(1, 0, j); end
    check("rise ignored in fall mode", o_width, 0);
    repeat (8) @(negedge clk);

    // Both edges on ch1, retrigger 2 cycles apart, PULSE_LEN=3 (cfg2).
    mode = 8'h5E; lvl[1] = 1'b0;
    obs_reset();
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk); obs_sample(2, 1, j);
      if (j == 2) lvl[1] = 1'b1;
    end
    check("retrig first", o_first, 2);
    check("retrig width", o_width, 5);
    check("retrig runs",  o_runs,  1);
    repeat (8) @(negedge clk);

    // RETRIG=0, PULSE_LEN=5 on ch3 (cfg3): ignored edge, MISSED handling.
    mode = 8'hDE; lvl[3] = 1'b0;
    obs_reset();
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk); obs_sample(3, 3, j);
      if (j == 2) lvl[3] = 1'b1;
    end
    check("noretrig width", o_width, 5);
    check("noretrig runs",  o_runs,  1);
    check("missed set",     32'(missed_w[3][3]), 32'h1);
    clr = 4'b1000; @(negedge clk); clr = '0; @(negedge clk);
    check("missed cleared", 32'(missed_w[3][3]), 32'h0);
    lvl[3] = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 2) begin lvl[3] = 1'b1; clr = 4'b1000; end
      if (j == 3) clr = '0;
    end
    check("set beats clear", 32'(missed_w[3][3]), 32'h1);
    clr = 4'b1000; @(negedge clk); clr = '0;
    lvl[3] = 1'b0;
    obs_reset();
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk); obs_sample(3, 3, j);
      if (j == 5) lvl[3] = 1'b1;
      if (j == 7) lvl[3] = 1'b0;
    end
    check("edge at last cycle width", o_width, 10);
    check("edge at last cycle runs",  o_runs,  2);
    check("edge at last cycle missed", 32'(missed_w[3][3]), 32'h1);
    check("RETRIG=1 MISSED tied low", 32'(missed_w[0]), 32'h0);
    repeat (8) @(negedge clk);

    // Mode 00 on ch2 while toggling, then enable rising with the level high.
    mode = 8'hCE;
    hi_cnt = 0;
    for (int j = 1; j <= 14; j++) begin
      if (j <= 6) lvl[2] = ~lvl[2];
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) hi_cnt += int'(pulse_w[g][2]);
    end
    check("mode off silent", hi_cnt, 0);
    mode = 8'hDE;
    obs_reset();
    for (int j = 1; j <= 8; j++) begin @(negedge clk); obs_sample(0, 2, j); end
    check("enable while high silent", o_width, 0);
    lvl[2] = 1'b0;
    obs_reset();
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk); obs_sample(0, 2, j);
      if (j == 2) lvl[2] = 1'b1;
    end
    check("next rise first", o_first, 5);
    check("next rise width", o_width, 1);

    // Reset in the 2nd cycle of a 4-cycle pulse (cfg1 ch0).
    mode = 8'h55; lvl = '0;
    repeat (8) @(negedge clk);
    lvl[0] = 1'b1; @(negedge clk); lvl[0] = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 10 && !seen; j++) begin
      @(negedge clk);
      if (pulse_w[1][0]) seen = 1'b1;
    end
    check("abort pulse started", 32'(seen), 32'h1);
    @(negedge clk);
    check("abort second cycle high", 32'(pulse_w[1][0]), 32'h1);
    rst = 1'b1; @(negedge clk);
    for (int g = 0; g < NCFG; g++)
      check($sformatf("abort cfg%0d PULSE_SIG", g), 32'(pulse_w[g]), 32'h0);
    rst = 1'b0;
    hi_cnt = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) hi_cnt += $countones(pulse_w[g]);
    end
    check("no residual pulse", hi_cnt, 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) mode = 8'($urandom);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 3) == 0) lvl[c] = ~lvl[c];
        clr[c] = ($urandom_range(0, 7) == 0);
      end
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multi_pulse_gen.md
Name: multi_pulse_gen

Overview:
- Parametrised multi-channel level-to-pulse converter. Successor to the single-channel, rising-edge-only, one-cycle pulse generator.
- Per channel it provides:
  - an optional input synchroniser
  - a selectable edge mode (rise, fall, both, off)
  - a stretched output pulse of PULSE_LEN cycles
  - a retrigger policy
  - a sticky missed-edge flag
- Sits between CDC'd control levels, such as register-file enables and UART/ALU handshake levels, and single-clock consumers that need strobes.

Parameters:
- NUM_CH, 4: number of independent channels (>=1).
- SYNC_STAGES, 2: synchroniser flops per channel (0..4). 0 means LVL_SIG is sampled directly.
- PULSE_LEN, 1: output pulse width in CLK cycles (1..255).
- RETRIG, 1: 1 = an edge during an active pulse restarts the length count. 0 = the edge is ignored and flagged in MISSED.
- CNT_W, $clog2(PULSE_LEN+1): stretch counter width (derived, not overridden).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- LVL_SIG  input  NUM_CH  level inputs, may be asynchronous when SYNC_STAGES>0.
- EDGE_MODE  input  2*NUM_CH  per channel, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both. Sampled every cycle.
- MISSED_CLR  input  NUM_CH  per-channel clear of MISSED.
- PULSE_SIG  output  NUM_CH  registered pulse outputs.
- BUSY  output  NUM_CH  channel currently driving a pulse (equals PULSE_SIG, provided for status readback).
- MISSED  output  NUM_CH  sticky: edge ignored while busy (RETRIG=0 only).

Behaviour:
- Reset: one clock, synchronous, active-high. While RST=1 at a CLK edge, every flop clears to 0:
  - sync chain, previous-sample register, counters
  - PULSE_SIG, BUSY, MISSED
- Synchroniser: s = output of a SYNC_STAGES-deep flop chain on LVL_SIG[i]. With SYNC_STAGES=0, s = LVL_SIG[i].
- Edge detect: prev <= s each cycle.
  - rise = s & ~prev; fall = ~s & prev.
  - edge = (mode[0] & rise) | (mode[1] & fall).
  - prev resets to 0, so a level already high when reset releases counts as a rising edge.
- Per-channel state machine:
  - IDLE: edge -> ACTIVE; cnt <= PULSE_LEN-1; PULSE_SIG <= 1.
  - ACTIVE, cnt!=0, no edge: cnt <= cnt-1.
  - ACTIVE, cnt==0, no edge: -> IDLE; PULSE_SIG <= 0.
  - ACTIVE, edge, RETRIG=1: cnt <= PULSE_LEN-1; stay ACTIVE. This extends the pulse with no gap.
  - ACTIVE, edge, RETRIG=0: cnt continues as normal; MISSED[i] <= 1.
  - An edge on the same cycle as cnt==0 with RETRIG=0 is also missed. The output falls, and the next edge restarts it.
- Latency: input toggle to PULSE_SIG rise = SYNC_STAGES+1 CLK cycles. The output is registered and is never combinational from LVL_SIG.
- Width: an isolated edge gives exactly PULSE_LEN high cycles.
- Back-to-back: with PULSE_LEN=1, RETRIG=1 and mode 11 on a toggling-every-cycle input, PULSE_SIG stays continuously high.
- EDGE_MODE change: affects only edges detected after the change. An in-flight pulse completes. Mode 00 suppresses new edges, and prev keeps tracking s.
- MISSED: set has priority over MISSED_CLR in the same cycle. Tied to 0 when RETRIG=1.
- Channels are fully independent, with no arbitration.
- Mid-operation reset: the active pulse aborts and the output is 0 on the cycle after the RST edge.

Decomposition:
- Shared package pulse_gen_pkg holds:
  - mode localparams MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11
  - state encoding ST_IDLE/ST_ACTIVE
  - MAX_SYNC_STAGES=4 and MAX_PULSE_LEN=255
- One sub-module, pulse_gen_ch, covers a single channel: sync chain, edge detect, counter, MISSED.
- The top level is a generate loop over NUM_CH plus parameter range checks.

Test Plan:
- Reset hold with LVL_SIG=4'hF, then release RST with EDGE_MODE all 01, SYNC_STAGES=2, PULSE_LEN=1 -> all PULSE_SIG high exactly 1 cycle, 3 cycles after RST falls. MISSED=0.
- Ch0 mode 10, PULSE_LEN=4: LVL_SIG[0] 1->0 -> PULSE_SIG[0] high 4 consecutive cycles starting 3 cycles later. A rising edge produces nothing.
- Ch1 mode 11, PULSE_LEN=3, RETRIG=1: edges 2 cycles apart -> a single pulse 2+3=5 cycles wide, with no low gap.
- RETRIG=0, PULSE_LEN=5: second edge 2 cycles into the pulse -> pulse is still 5 cycles and MISSED[i]=1 stays set. MISSED_CLR pulse -> 0. Clear coinciding with a new miss -> stays 1.
- Mode 00 on ch2 while toggling -> PULSE_SIG[2]=0. Switch to 01 while the level is high -> no pulse until the next rise.
- Assert RST on the 2nd cycle of a 4-cycle pulse -> PULSE_SIG=0 next cycle, counters cleared, no residual pulse after release.
